// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard inputs, stage controls and perf counters of the stall sequencer
interface pipe_stall_ctrl_if #(parameter int CNT_W = 32);
   logic             mem_busy;
   logic             branch_taken;
   logic             load_use;
   logic             dbg_halt;
   logic             dbg_step;
   logic             cnt_clr;
   logic             pc_ce;
   logic             fd_ce;
   logic             dx_ce;
   logic             xw_ce;
   logic             fd_flush;
   logic             dx_flush;
   logic             xw_flush;
   logic             halted;
   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] freeze_cnt;

   // core side: raises hazards, consumes stage controls
   modport master (
      output mem_busy, branch_taken, load_use, dbg_halt, dbg_step, cnt_clr,
      input  pc_ce, fd_ce, dx_ce, xw_ce, fd_flush, dx_flush, xw_flush,
      input  halted, bubble_cnt, freeze_cnt
   );

   // sequencer side
   modport slave (
      input  mem_busy, branch_taken, load_use, dbg_halt, dbg_step, cnt_clr,
      output pc_ce, fd_ce, dx_ce, xw_ce, fd_flush, dx_flush, xw_flush,
      output halted, bubble_cnt, freeze_cnt
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline ce/flush sequencer with boot hold, hazards, debug halt and perf counters
module pipe_stall_ctrl #(
   parameter int BOOT_CYCLES  = 4,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipe_stall_ctrl_if.slave bus
);
   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int FW = $clog2(FLUSH_CYCLES + 2);

   localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_CYCLES - 1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
   localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);
   localparam bit            HAS_FLUSH  = (FLUSH_CYCLES > 0);

   localparam logic [2:0] S_BOOT  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_HALT  = 3'd3;
   localparam logic [2:0] S_STEP  = 3'd4;

   logic [2:0]       r_state;
   logic [BW-1:0]    r_boot_cnt;
   logic [FW-1:0]    r_flush_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;
   logic [CNT_W-1:0] r_freeze_cnt;

   logic [2:0]       w_next_state;
   logic [BW-1:0]    w_boot_cnt_nxt;
   logic [FW-1:0]    w_flush_cnt_nxt;
   logic             w_pc_ce, w_fd_ce, w_dx_ce, w_xw_ce;
   logic             w_fd_flush, w_dx_flush, w_xw_flush;
   logic             w_freeze_inc;
   logic             w_bubble_inc;

   // stage controls and next state; reset cycle looks like a boot cycle at the outputs
   always_comb begin
      w_next_state    = r_state;
      w_boot_cnt_nxt  = r_boot_cnt;
      w_flush_cnt_nxt = r_flush_cnt;
      w_pc_ce         = 1'b0;
      w_fd_ce         = 1'b0;
      w_dx_ce         = 1'b0;
      w_xw_ce         = 1'b0;
      w_fd_flush      = 1'b0;
      w_dx_flush      = 1'b0;
      w_xw_flush      = 1'b0;
      w_freeze_inc    = 1'b0;
      if (rst) begin
         w_fd_flush = 1'b1;
         w_dx_flush = 1'b1;
         w_xw_flush = 1'b1;
      end else begin
         case (r_state)
            S_RUN, S_STEP: begin
               if (bus.mem_busy) begin
                  w_freeze_inc = 1'b1;
               end else if (bus.dbg_halt && (r_state == S_RUN)) begin
                  w_next_state = S_HALT;
               end else if (bus.branch_taken) begin
                  w_pc_ce    = 1'b1;
                  w_fd_ce    = 1'b1;
                  w_dx_ce    = 1'b1;
                  w_xw_ce    = 1'b1;
                  w_fd_flush = 1'b1;
                  w_dx_flush = 1'b1;
                  if (HAS_FLUSH) begin
                     w_next_state    = S_FLUSH;
                     w_flush_cnt_nxt = FLUSH_LOAD;
                  end else if (r_state == S_STEP) begin
                     w_next_state = S_HALT;
                  end
               end else if (bus.load_use) begin
                  w_xw_ce    = 1'b1;
                  w_dx_flush = 1'b1;
                  if (r_state == S_STEP) w_next_state = S_HALT;
               end else begin
                  w_pc_ce = 1'b1;
                  w_fd_ce = 1'b1;
                  w_dx_ce = 1'b1;
                  w_xw_ce = 1'b1;
                  if (r_state == S_STEP) w_next_state = S_HALT;
               end
            end
            S_FLUSH: begin
               if (bus.mem_busy) begin
                  w_freeze_inc = 1'b1;
               end else begin
                  w_pc_ce    = 1'b1;
                  w_dx_ce    = 1'b1;
                  w_xw_ce    = 1'b1;
                  w_fd_flush = 1'b1;
                  w_flush_cnt_nxt = r_flush_cnt - FLUSH_ONE;
                  if (r_flush_cnt <= FLUSH_ONE) begin
                     w_next_state = bus.dbg_halt ? S_HALT : S_RUN;
                  end
               end
            end
            S_HALT: begin
               if (!bus.dbg_halt) begin
                  w_next_state = S_RUN;
               end else if (bus.dbg_step) begin
                  w_next_state = S_STEP;
               end
            end
            default: begin
               w_fd_flush = 1'b1;
               w_dx_flush = 1'b1;
               w_xw_flush = 1'b1;
               if (r_state != S_BOOT) begin
                  w_next_state   = S_BOOT;
                  w_boot_cnt_nxt = '0;
               end else if (r_boot_cnt == BOOT_LAST) begin
                  w_next_state = S_RUN;
               end else begin
                  w_boot_cnt_nxt = r_boot_cnt + 1'b1;
               end
            end
         endcase
      end
      w_bubble_inc = w_dx_flush && !rst && (r_state != S_BOOT);
   end

   // state register and boot/redirect counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_BOOT;
         r_boot_cnt  <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_boot_cnt  <= w_boot_cnt_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // saturating perf counters; clear takes precedence over a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || bus.cnt_clr) begin
         r_bubble_cnt <= '0;
         r_freeze_cnt <= '0;
      end else begin
         if (w_bubble_inc && (r_bubble_cnt != {CNT_W{1'b1}})) r_bubble_cnt <= r_bubble_cnt + 1'b1;
         if (w_freeze_inc && (r_freeze_cnt != {CNT_W{1'b1}})) r_freeze_cnt <= r_freeze_cnt + 1'b1;
      end
   end

   assign bus.pc_ce      = w_pc_ce;
   assign bus.fd_ce      = w_fd_ce;
   assign bus.dx_ce      = w_dx_ce;
   assign bus.xw_ce      = w_xw_ce;
   assign bus.fd_flush   = w_fd_flush;
   assign bus.dx_flush   = w_dx_flush;
   assign bus.xw_flush   = w_xw_flush;
   assign bus.halted     = (r_state == S_HALT) && !rst;
   assign bus.bubble_cnt = r_bubble_cnt;
   assign bus.freeze_cnt = r_freeze_cnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_stall_ctrl #(.BOOT_CYCLES(4), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // {pc_ce, fd_ce, dx_ce, xw_ce, fd_flush, dx_flush, xw_flush}
   localparam logic [6:0] O_BOOT   = 7'b0000111;
   localparam logic [6:0] O_RUN    = 7'b1111000;
   localparam logic [6:0] O_FRZ    = 7'b0000000;
   localparam logic [6:0] O_LU     = 7'b0001010;
   localparam logic [6:0] O_BR     = 7'b1111110;
   localparam logic [6:0] O_FLUSH  = 7'b1011100;

   logic [6:0] outs;
   assign outs = {bus.pc_ce, bus.fd_ce, bus.dx_ce, bus.xw_ce, bus.fd_flush, bus.dx_flush, bus.xw_flush};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // apply one cycle of inputs at the falling edge; outputs settle before the next rising edge
   task automatic cyc(input logic r, input logic mb, input logic br, input logic lu,
                      input logic dh, input logic ds, input logic clr);
      @(negedge clk);
      rst              = r;
      bus.mem_busy     = mb;
      bus.branch_taken = br;
      bus.load_use     = lu;
      bus.dbg_halt     = dh;
      bus.dbg_step     = ds;
      bus.cnt_clr      = clr;
      #1;
   endtask

   initial begin
      bus.mem_busy = 0; bus.branch_taken = 0; bus.load_use = 0;
      bus.dbg_halt = 0; bus.dbg_step = 0; bus.cnt_clr = 0;

      // reset cycle
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      check("rst_outs", 32'(outs), 32'(O_BOOT));
      check("rst_halted", 32'(bus.halted), 32'd0);

      // boot hold: four cycles flushed, inputs ignored
      cyc(0, 0, 1, 1, 0, 0, 0);
      check("boot0_outs", 32'(outs), 32'(O_BOOT));
      check("boot0_bubble", 32'(bus.bubble_cnt), 32'd0);
      check("boot0_freeze", 32'(bus.freeze_cnt), 32'd0);
      for (int i = 1; i < 4; i++) begin
         cyc(0, 1, 0, 0, 0, 0, 0);
         check("boot_outs", 32'(outs), 32'(O_BOOT));
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("run_first", 32'(outs), 32'(O_RUN));
      check("run_bubble0", 32'(bus.bubble_cnt), 32'd0);
      check("run_freeze0", 32'(bus.freeze_cnt), 32'd0);

      // load-use bubble
      cyc(0, 0, 0, 1, 0, 0, 0);
      check("lu_outs", 32'(outs), 32'(O_LU));
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("lu_after", 32'(outs), 32'(O_RUN));
      check("lu_bubble", 32'(bus.bubble_cnt), 32'd1);

      // branch redirect with one extra flush cycle; branch beats load_use
      cyc(0, 0, 1, 1, 0, 0, 0);
      check("br_outs", 32'(outs), 32'(O_BR));
      cyc(0, 0, 1, 1, 0, 0, 0);
      check("br_flush", 32'(outs), 32'(O_FLUSH));
      check("br_bubble", 32'(bus.bubble_cnt), 32'd2);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("br_run", 32'(outs), 32'(O_RUN));
      check("br_bubble2", 32'(bus.bubble_cnt), 32'd2);

      // branch then memory freeze inside FLUSH
      cyc(0, 0, 1, 0, 0, 0, 0);
      check("br2_outs", 32'(outs), 32'(O_BR));
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0, 0, 0, 0);
         check("flush_frz", 32'(outs), 32'(O_FRZ));
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("flush_resume", 32'(outs), 32'(O_FLUSH));
      check("flush_freeze3", 32'(bus.freeze_cnt), 32'd3);
      check("flush_bubble", 32'(bus.bubble_cnt), 32'd3);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("flush_exit", 32'(outs), 32'(O_RUN));

      // mem_busy beats dbg_halt in RUN
      cyc(0, 1, 1, 0, 1, 0, 0);
      check("run_frz", 32'(outs), 32'(O_FRZ));
      check("run_frz_halted", 32'(bus.halted), 32'd0);

      // debug halt, step, resume
      cyc(0, 0, 1, 0, 1, 0, 0);
      check("halt_req", 32'(outs), 32'(O_FRZ));
      check("halt_freeze4", 32'(bus.freeze_cnt), 32'd4);
      cyc(0, 1, 0, 0, 1, 0, 0);
      check("halted", 32'(bus.halted), 32'd1);
      check("halted_outs", 32'(outs), 32'(O_FRZ));
      cyc(0, 0, 0, 0, 1, 1, 0);
      check("halt_nocount", 32'(bus.freeze_cnt), 32'd4);
      check("step_req_halted", 32'(bus.halted), 32'd1);
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("step_outs", 32'(outs), 32'(O_RUN));
      check("step_halted", 32'(bus.halted), 32'd0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("step_back", 32'(bus.halted), 32'd1);
      check("step_back_outs", 32'(outs), 32'(O_FRZ));
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("resume_wait", 32'(bus.halted), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("resume_run", 32'(outs), 32'(O_RUN));
      check("resume_halted", 32'(bus.halted), 32'd0);

      // clear wins over same-cycle increments
      cyc(0, 0, 0, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("clr_bubble", 32'(bus.bubble_cnt), 32'd0);
      check("clr_freeze", 32'(bus.freeze_cnt), 32'd0);

      // saturation: 20 bubbles into a 4-bit counter
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("sat_bubble", 32'(bus.bubble_cnt), 32'd15);
      check("sat_freeze", 32'(bus.freeze_cnt), 32'd0);

      // dbg_halt ignored inside FLUSH, honoured on exit
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("flush_dbg_outs", 32'(outs), 32'(O_FLUSH));
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("flush_to_halt", 32'(bus.halted), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("halt_to_run", 32'(outs), 32'(O_RUN));

      // reset during FLUSH restarts boot with cleared counters
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      check("rst_flush_outs", 32'(outs), 32'(O_BOOT));
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0);
         check("reboot_outs", 32'(outs), 32'(O_BOOT));
      end
      check("reboot_bubble", 32'(bus.bubble_cnt), 32'd0);
      check("reboot_freeze", 32'(bus.freeze_cnt), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("reboot_run", 32'(outs), 32'(O_RUN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
